// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared FSM state type and sizing helpers for the data bus arbiter
package data_bus_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int rd_lat(input bit sync_ram);
    return sync_ram ? 1 : 0;
  endfunction
endpackage

// File: rtl/data_bus_arbiter_rr_priority_picker.sv
// data_bus_arbiter_rr_priority_picker: first requester after ptr_i (wrapping) as one-hot and index
// req_i: request vector, ptr_i: scan starts at ptr_i+1, gnt_o: one-hot winner (0 if none), idx_o: winner index
module data_bus_arbiter_rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic hit;
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    hit = 1'b0;
    idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!hit && req_i[j]) begin
        hit = 1'b1;
        idx_o = j;
      end
    end
  end
  assign gnt_o = hit ? N'(1) << idx_o : '0;
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter sharing one data-side slave bus between several masters
// m_req/m_addr/m_wdata/m_wr_*: per-master request and transfer fields, packed master i at slice i
// m_gnt: one-hot owner, m_rd_valid/m_rd_data: routed read return
// s_addr/s_wdata/s_wr_*: owner's transfer to the slave, s_rd_data: slave read data
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int    NR_OF_MASTERS   = 2,
  parameter int    ADDR_BUS_WIDTH  = 16,
  parameter string SYNCHRONOUS_RAM = "TRUE",
  parameter int    MAX_BURST       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NR_OF_MASTERS-1:0]                 m_req,
  input  logic [NR_OF_MASTERS*ADDR_BUS_WIDTH-1:0]  m_addr,
  input  logic [NR_OF_MASTERS*32-1:0]              m_wdata,
  input  logic [NR_OF_MASTERS-1:0]                 m_wr_w,
  input  logic [NR_OF_MASTERS-1:0]                 m_wr_h,
  input  logic [NR_OF_MASTERS-1:0]                 m_wr_b,
  output logic [NR_OF_MASTERS-1:0]                 m_gnt,
  output logic [NR_OF_MASTERS-1:0]                 m_rd_valid,
  output logic [31:0]                              m_rd_data,
  output logic [ADDR_BUS_WIDTH-1:0]                s_addr,
  output logic [31:0]                              s_wdata,
  output logic                                     s_wr_w,
  output logic                                     s_wr_h,
  output logic                                     s_wr_b,
  input  logic [31:0]                              s_rd_data
);
  localparam int N   = NR_OF_MASTERS;
  localparam int AW  = ADDR_BUS_WIDTH;
  localparam int IW  = idx_w(N);
  localparam int BW  = idx_w(MAX_BURST);
  localparam int LAT = rd_lat(SYNCHRONOUS_RAM == "TRUE");
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, rd_owner_q;
  logic [BW-1:0] burst_q, burst_d;
  logic          rd_q;
  logic [N-1:0]  owner_oh, pick_oh;
  logic [IW-1:0] pick_idx;
  logic          busy, own_req, others, is_rd;

  assign busy     = state_q == BUSY;
  assign owner_oh = N'(1) << owner_q;
  assign own_req  = busy & m_req[owner_q];
  assign others   = |(m_req & ~owner_oh);

  // In BUSY the scan starts after the current owner, so a rotation never re-picks it while others wait
  data_bus_arbiter_rr_priority_picker #(.N(N), .IW(IW)) u_pick (
    .req_i (m_req),
    .ptr_i (busy ? owner_q : rr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    if (!busy) begin
      if (|pick_oh) begin
        state_d = BUSY;
        owner_d = pick_idx;
        burst_d = '0;
      end
    end else if (~|m_req) begin
      state_d = IDLE;
      rr_d    = owner_q;
      burst_d = '0;
    end else if (m_req[owner_q] && (burst_q < BMAX || !others)) begin
      burst_d = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
    end else begin
      owner_d = pick_idx;
      rr_d    = owner_q;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= IW'(N - 1);
      burst_q    <= '0;
      rd_q       <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      rd_q       <= is_rd;
      rd_owner_q <= owner_q;
    end
  end

  assign s_addr  = busy ? m_addr[int'(owner_q)*AW +: AW] : '0;
  assign s_wdata = busy ? m_wdata[int'(owner_q)*32 +: 32] : '0;
  assign s_wr_w  = own_req & m_wr_w[owner_q];
  assign s_wr_h  = own_req & m_wr_h[owner_q];
  assign s_wr_b  = own_req & m_wr_b[owner_q];
  assign is_rd   = own_req & ~(s_wr_w | s_wr_h | s_wr_b);

  // Owner id travels with the read so the valid lands on the issuer even after ownership moves on
  assign m_gnt      = busy ? owner_oh : '0;
  assign m_rd_valid = (LAT != 0) ? (rd_q ? N'(1) << rd_owner_q : '0) : (is_rd ? owner_oh : '0);
  assign m_rd_data  = s_rd_data;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed self-checking bench for data_bus_arbiter (3 masters, sync RAM, burst 4)
module tb_data_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req, m_wr_w, m_wr_h, m_wr_b;
  logic [47:0] m_addr;
  logic [95:0] m_wdata;
  logic [2:0]  m_gnt, m_rd_valid;
  logic [31:0] m_rd_data, s_wdata, s_rd_data;
  logic [15:0] s_addr;
  logic        s_wr_w, s_wr_h, s_wr_b;
  logic [2:0]  eg, prev;
  int n_chk = 0;
  int n_fail = 0;

  data_bus_arbiter #(
    .NR_OF_MASTERS(3), .ADDR_BUS_WIDTH(16), .SYNCHRONOUS_RAM("TRUE"), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wr_w(m_wr_w), .m_wr_h(m_wr_h), .m_wr_b(m_wr_b), .m_gnt(m_gnt),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wr_w(s_wr_w), .s_wr_h(s_wr_h), .s_wr_b(s_wr_b), .s_rd_data(s_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; m_req = 3'b011; m_wr_w = '0; m_wr_h = '0; m_wr_b = '0;
    m_addr = '0; m_wdata = '0; s_rd_data = '0;
    step(); step();
    chk("rst_gnt", m_gnt, 0);
    chk("rst_rdv", m_rd_valid, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_swdata", s_wdata, 0);
    chk("rst_swr", {s_wr_w, s_wr_h, s_wr_b}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("burst_gnt", m_gnt, (i < 4) ? 3'b001 : 3'b010);
    end
    m_req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("solo_gnt", m_gnt, 3'b010);
    end
    m_addr[16 +: 16] = 16'h2000; m_wdata[32 +: 32] = 32'h0000_00A5; m_wr_w = 3'b010;
    #1;
    chk("wr_sww", s_wr_w, 1);
    chk("wr_swhb", {s_wr_h, s_wr_b}, 0);
    chk("wr_saddr", s_addr, 16'h2000);
    chk("wr_swdata", s_wdata, 32'h0000_00A5);
    m_req = 3'b000;
    #1;
    chk("wr_gated", s_wr_w, 0);
    step();
    chk("idle_gnt", m_gnt, 0);
    m_wr_w = '0; m_req = 3'b001; m_addr[0 +: 16] = 16'h4010; s_rd_data = 32'hCAFE_F00D;
    step();
    chk("rd_gnt", m_gnt, 3'b001);
    chk("rd_saddr", s_addr, 16'h4010);
    chk("rd_rdv_t", m_rd_valid, 0);
    step();
    chk("rd_rdv_t1", m_rd_valid, 3'b001);
    chk("rd_data", m_rd_data, 32'hCAFE_F00D);
    m_req = 3'b000;
    step();
    chk("rd_rdv_t2", m_rd_valid, 0);
    chk("rd_idle", m_gnt, 0);
    m_req = 3'b010; m_addr[16 +: 16] = 16'h1234;
    step();
    chk("m1_gnt", m_gnt, 3'b010);
    chk("m1_saddr", s_addr, 16'h1234);
    step();
    chk("m1_rdv", m_rd_valid, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", m_gnt, 0);
    chk("arst_rdv", m_rd_valid, 0);
    chk("arst_saddr", s_addr, 0);
    chk("arst_swr", {s_wr_w, s_wr_h, s_wr_b}, 0);
    m_req = 3'b111;
    @(posedge clk);
    #1 rst = 1'b0;
    prev = '0;
    for (int i = 0; i < 13; i++) begin
      step();
      eg = 3'b001 << ((i / 4) % 3);
      chk("rr3_gnt", m_gnt, eg);
      chk("rr3_rdv", m_rd_valid, prev);
      prev = eg;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
